// File: rtl/reg_file_pkg.sv
// Shared register-file types and default sizing, used by reg_file, the ALU and
// the decoder so that all three agree on word and register-address widths.
package reg_file_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = $clog2(NREGS);

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_word_t;

endpackage : reg_file_pkg

// File: rtl/reg_file_if.sv
// Register-file port bundle: two combinational read ports and one write port.
// The master is the datapath (decoder/writeback); the slave is reg_file.
interface reg_file_if #(
    parameter int XLEN   = reg_file_pkg::XLEN,
    parameter int ADDR_W = reg_file_pkg::REG_ADDR_W
);

    logic [ADDR_W-1:0] A1;   // rs1
    logic [ADDR_W-1:0] A2;   // rs2
    logic [ADDR_W-1:0] A3;   // rd
    logic [XLEN-1:0]   WD3;  // writeback data
    logic              WE3;  // RegWrite
    logic [XLEN-1:0]   RD1;  // to ALU SrcA
    logic [XLEN-1:0]   RD2;  // to SrcB mux / store data

    modport master (output A1, A2, A3, WD3, WE3, input RD1, RD2);
    modport slave  (input A1, A2, A3, WD3, WE3, output RD1, RD2);

endinterface : reg_file_if

// File: rtl/reg_file.sv
// RISC-V style integer register file: x0 hard-wired to zero, x1..x(NREGS-1)
// stored in flops, two combinational read ports, one synchronous write port.
// Optional feature: define REG_FILE_BYPASS_EN to forward same-cycle write data
// onto a read port whose address matches the write address. Storage and write
// behaviour are identical with or without the macro.
module reg_file #(
    parameter int XLEN  = reg_file_pkg::XLEN,
    parameter int NREGS = reg_file_pkg::NREGS
) (
    input  logic       clk,
    input  logic       rst_n,
    reg_file_if.slave  bus
);

    localparam int AW = $clog2(NREGS);

    // x0 has no storage; index range starts at 1.
    logic [XLEN-1:0] regs_q [1:NREGS-1];
    logic [XLEN-1:0] regs_d [1:NREGS-1];

    // Writes are armed only from the second edge after reset release, so a
    // write presented on the edge where reset goes away never lands.
    logic wr_arm_q;
    logic wr_arm_d;
    logic wr_en;

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    // Stored-value lookup; address 0 and any unmapped address read as zero.
    function automatic logic [XLEN-1:0] stored_value(input logic [AW-1:0] addr);
        stored_value = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (addr == AW'(i)) stored_value = regs_q[i];
        end
    endfunction

    // Next-state for storage and the write-arm flag.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        regs_d   = regs_q;
        wr_arm_d = 1'b1;
        wr_en    = bus.WE3 && wr_arm_q && (bus.A3 != '0);
        for (int i = 1; i < NREGS; i++) begin
            if (wr_en && (bus.A3 == AW'(i))) regs_d[i] = bus.WD3;
        end
    end

    // State registers; reset clears every register without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this storage array is reset on purpose: architectural
            // registers must read zero after reset, so it cannot map to RAM.
            for (int i = 1; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_arm_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its pre-edge inputs regardless of statement order.
            regs_q   <= regs_d;
            wr_arm_q <= wr_arm_d;
        end
    end

    // Read muxes, with optional same-cycle forwarding from the write port.
    always_comb begin
        rd1 = stored_value(bus.A1);
        rd2 = stored_value(bus.A2);
`ifdef REG_FILE_BYPASS_EN
        // wr_en already excludes x0, so a forwarded read is never address 0.
        if (wr_en && (bus.A1 == bus.A3)) rd1 = bus.WD3;
        if (wr_en && (bus.A2 == bus.A3)) rd2 = bus.WD3;
`endif
    end

    assign bus.RD1 = rd1;
    assign bus.RD2 = rd2;

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file. Expected read values are queued when a
// cycle's inputs are driven and compared on the following falling edge.
// Builds with or without REG_FILE_BYPASS_EN; the model follows the same macro.
module tb_reg_file;
    import reg_file_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    reg_file_if #(.XLEN(XLEN), .ADDR_W(REG_ADDR_W)) bus ();

    reg_file #(.XLEN(XLEN), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        string      tag;
        xlen_word_t rd1;
        xlen_word_t rd2;
    } exp_t;

    exp_t       sb_q [$];
    xlen_word_t model [NREGS];
    bit         model_arm;
    int         n_checks = 0;
    int         n_errors = 0;

`ifdef REG_FILE_BYPASS_EN
    localparam xlen_word_t HAZARD_PRE = 32'h22;
`else
    localparam xlen_word_t HAZARD_PRE = 32'h11;
`endif

    task automatic check(input string tag, input xlen_word_t obs, input xlen_word_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        model_arm = 1'b0;
    endfunction

    // Reference read for the inputs currently on the bus.
    function automatic xlen_word_t model_rd(input reg_addr_t a);
        xlen_word_t v;
        v = (a == '0) ? '0 : model[a];
`ifdef REG_FILE_BYPASS_EN
        if (rst_n && model_arm && bus.WE3 && bus.A3 != '0 && a == bus.A3) v = bus.WD3;
`endif
        return v;
    endfunction

    // Reference state update for one rising edge.
    function automatic void model_edge();
        if (rst_n) begin
            if (model_arm && bus.WE3 && bus.A3 != '0) model[bus.A3] = bus.WD3;
            model_arm = 1'b1;
        end
    endfunction

    // One clock cycle: drive, queue expectation, compare at negedge, take edge.
    // Must be entered between a rising edge and the next falling edge.
    task automatic run_cycle(input string tag, input reg_addr_t a1, input reg_addr_t a2,
                             input reg_addr_t a3, input xlen_word_t wd, input logic we,
                             input bit use_model, input xlen_word_t e1 = '0,
                             input xlen_word_t e2 = '0);
        exp_t e;
        bus.A1  = a1;
        bus.A2  = a2;
        bus.A3  = a3;
        bus.WD3 = wd;
        bus.WE3 = we;
        e.tag = tag;
        e.rd1 = use_model ? model_rd(a1) : e1;
        e.rd2 = use_model ? model_rd(a2) : e2;
        sb_q.push_back(e);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, "_rd1"}, bus.RD1, e.rd1);
            check({e.tag, "_rd2"}, bus.RD2, e.rd2);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.WD3 = '0; bus.WE3 = 1'b0;
        rst_n = 1'b0;
        model_reset();

        // Reads while held in reset, with a write pending that must be dropped.
        @(posedge clk); #1;
        bus.WE3 = 1'b1; bus.A3 = 5'd3; bus.WD3 = 32'hCAFE_F00D;
        for (int i = 1; i < 4; i++) begin
            bus.A1 = reg_addr_t'(i);
            bus.A2 = reg_addr_t'(NREGS - i);
            #1;
            check("in_reset_rd1", bus.RD1, '0);
            check("in_reset_rd2", bus.RD2, '0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // First edge after release carries a write that must not land.
        run_cycle("release_wr", 5'd3, 5'd0, 5'd3, 32'hCAFE_F00D, 1'b1, 1'b0, '0, '0);

        // All registers read zero after reset.
        for (int i = 1; i < NREGS; i++) begin
            run_cycle("reset_sweep", reg_addr_t'(i), reg_addr_t'(NREGS - i), 5'd0, '0, 1'b0,
                      1'b0, '0, '0);
        end

        // Basic write then read.
        run_cycle("wr5", 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF, 1'b1, 1'b0, '0, '0);
        run_cycle("rd5", 5'd5, 5'd6, 5'd0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, '0);

        // x0 guard.
        run_cycle("wr_x0", 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0, '0, '0);
        run_cycle("rd_x0", 5'd0, 5'd0, 5'd0, '0, 1'b0, 1'b0, '0, '0);

        // WE3 low leaves state alone; equal addresses give equal data.
        run_cycle("we_low", 5'd0, 5'd0, 5'd5, 32'h0000_0001, 1'b0, 1'b0, '0, '0);
        run_cycle("same_addr", 5'd5, 5'd5, 5'd0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

        // Same-cycle read/write hazard.
        run_cycle("wr7", 5'd0, 5'd0, 5'd7, 32'h11, 1'b1, 1'b0, '0, '0);
        run_cycle("hazard", 5'd7, 5'd7, 5'd7, 32'h22, 1'b1, 1'b0, HAZARD_PRE, HAZARD_PRE);
        run_cycle("post_hazard", 5'd7, 5'd5, 5'd0, '0, 1'b0, 1'b0, 32'h22, 32'hDEAD_BEEF);

        // Mid-run asynchronous reset between clock edges.
        run_cycle("wr10", 5'd0, 5'd0, 5'd10, 32'hA5A5_A5A5, 1'b1, 1'b0, '0, '0);
        bus.A1 = 5'd10; bus.A2 = 5'd5; bus.WE3 = 1'b0;
        #1;
        check("pre_rst_rd1", bus.RD1, 32'hA5A5_A5A5);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_rst_rd1", bus.RD1, '0);
        check("async_rst_rd2", bus.RD2, '0);
        rst_n = 1'b1;
        run_cycle("mid_release_wr", 5'd10, 5'd0, 5'd10, 32'h1234_5678, 1'b1, 1'b0, '0, '0);
        run_cycle("post_mid_rst", 5'd10, 5'd5, 5'd0, '0, 1'b0, 1'b0, '0, '0);

        // Random traffic against the reference model, biased toward hazards.
        for (int n = 0; n < 10000; n++) begin
            reg_addr_t  a1, a2, a3;
            xlen_word_t wd;
            a3 = reg_addr_t'($urandom_range(NREGS - 1, 0));
            a1 = ($urandom_range(3, 0) == 0) ? a3 : reg_addr_t'($urandom_range(NREGS - 1, 0));
            a2 = ($urandom_range(3, 0) == 0) ? a3 : reg_addr_t'($urandom_range(NREGS - 1, 0));
            wd = $urandom();
            run_cycle("rand", a1, a2, a3, wd, logic'($urandom_range(1, 0)), 1'b1);
        end

        check("sb_drained", 32'(sb_q.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_reg_file

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter XLEN, default 32: data width of every register and data port.
REQ-002 Parameter NREGS, default 32: number of architectural registers; address width is log2(NREGS) = 5 at default.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 A1  input  5  read-port-1 address (rs1).
REQ-006 A2  input  5  read-port-2 address (rs2).
REQ-007 A3  input  5  write-port address (rd).
REQ-008 WD3  input  XLEN  write data from the ALUResult/writeback mux.
REQ-009 WE3  input  1  write enable (RegWrite).
REQ-010 RD1  output  XLEN  read data 1; feeds ALU SrcA.
REQ-011 RD2  output  XLEN  read data 2; feeds SrcB mux and store data.

Function
REQ-012 Storage SHALL be registers x1..x(NREGS-1), XLEN bits each; x0 SHALL have no storage.
REQ-013 Reads SHALL be combinational: RD1 = reg[A1], RD2 = reg[A2], zero cycles latency.
REQ-014 A1 == 0 or A2 == 0 SHALL return 0 on the corresponding port, regardless of any write.
REQ-015 Write SHALL occur on the rising clk edge when WE3 = 1, rst_n = 1 and A3 != 0: reg[A3] <= WD3.
REQ-016 WE3 = 1 with A3 = 0 SHALL leave all state unchanged.
REQ-017 WE3 = 0 SHALL leave all state unchanged regardless of A3/WD3.
REQ-018 A write to reg[A3] SHALL be visible on RD1/RD2 from the cycle after the write edge.
REQ-019 A1 == A2 SHALL give identical values on RD1 and RD2.
REQ-020 Same-cycle read and write of the same register (A1 or A2 == A3, WE3 = 1) SHALL follow REQ-028/029.
REQ-021 RD1/RD2 SHALL never be X once rst_n has been asserted at least once.

Reset
REQ-022 rst_n low SHALL immediately and asynchronously clear x1..x(NREGS-1) to 0, with no clock edge needed.
REQ-023 While rst_n is low, RD1 and RD2 SHALL read 0 for every address.
REQ-024 Writes presented while rst_n is low SHALL be discarded, including a write on the edge where rst_n deasserts.
REQ-025 Reset asserted mid-program SHALL clear all registers; no partial write SHALL survive.

Configuration
REQ-026 Macro REG_FILE_BYPASS_EN SHALL select same-cycle write-to-read forwarding.
REQ-027 The macro SHALL affect only the read path; storage and write behaviour are identical either way.
REQ-028 With REG_FILE_BYPASS_EN defined: if WE3 = 1, A3 != 0 and Ax == A3, RDx SHALL equal WD3 combinationally in that cycle.
REQ-029 Without REG_FILE_BYPASS_EN: RDx SHALL return the pre-write stored value in that cycle.

Structure
REQ-030 Shared package SHALL hold XLEN, NREGS, REG_ADDR_W and the reg_addr_t/xlen_word_t typedefs, for use by reg_file, alu and the decoder.
REQ-031 No sub-module SHALL be used; the storage array, write logic and read/bypass muxes are in reg_file.

Verification
REQ-032 Reset: drive rst_n = 0, then release; read A1 = 1..31 and A2 = 31..1 -> every RD1/RD2 = 0.
REQ-033 Write/read: WE3 = 1, A3 = 5, WD3 = 32'hDEADBEEF, one edge; then A1 = 5 -> RD1 = 32'hDEADBEEF; A2 = 6 -> RD2 = 0.
REQ-034 x0 guard: WE3 = 1, A3 = 0, WD3 = 32'hFFFFFFFF, edge; then A1 = 0, A2 = 0 -> RD1 = RD2 = 0.
REQ-035 Same-cycle hazard: reg[7] = 32'h11 first; then in one cycle WE3 = 1, A3 = 7, WD3 = 32'h22, A1 = 7.
- RD1 = 32'h22 before the edge with the macro, 32'h11 without it.
- RD1 = 32'h22 after the edge in both builds.
REQ-036 Mid-run reset: reg[10] = 32'hA5A5A5A5; pulse rst_n low between clock edges -> RD1 (A1 = 10) drops to 0 within the low phase with no edge; a write on the release edge does not land.
REQ-037 Random: 10k random A1/A2/A3/WD3/WE3 cycles against a 32-entry reference model with the same bypass setting -> zero mismatches, and x0 always 0.
